mem_stream_loader: RTL and testbench
====================================

MEM_STREAM_LOADER -- requirements
Module: mem_stream_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, host/memory word width.
REQ-002 SHALL have parameter ADDR_W, default 12, data-memory address width; capacity 2^ADDR_W words.
REQ-003 SHALL have parameter NUM_CORES, default 4, number of processor cores driven.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port com_data_in  input  DATA_W  host load word.
REQ-007 SHALL have port data_write_start  input  1  host has load words to send.
REQ-008 SHALL have port data_write_done  input  1  current com_data_in is the last load word.
REQ-009 SHALL have port com_data_out  output  DATA_W  unload word.
REQ-010 SHALL have port output_write_start  output  1  com_data_out valid this cycle.
REQ-011 SHALL have port output_write_done  output  1  current unload word is the last.
REQ-012 SHALL have port state  output  2  FSM state: 0 IDLE, 1 LOAD, 2 RUN, 3 UNLOAD.
REQ-013 SHALL have ports mem_addr output ADDR_W, mem_wdata output DATA_W, mem_we output 1, mem_rdata input DATA_W (read data valid one cycle after mem_addr).
REQ-014 SHALL have ports core_start output NUM_CORES (start pulse), core_done input NUM_CORES (per-core completion level).
REQ-015 SHALL have port load_ovf  output  1  sticky: load words were discarded.

Function
REQ-016 IDLE: move to LOAD on data_write_start=1; all handshake outputs low.
REQ-017 LOAD: every cycle write com_data_in to mem_addr=wr_ptr with mem_we=1, wr_ptr++; count = words written.
REQ-018 LOAD: word sampled with data_write_done=1 is written and is the last; next state RUN; minimum count is 1.
REQ-019 Full: after address 2^ADDR_W-1 is written, later words are not written (mem_we=0), load_ovf=1, count saturates at 2^ADDR_W.
REQ-020 RUN entry: core_start = all ones for exactly one cycle; per-core done flags cleared that same cycle.
REQ-021 RUN: core_done bits are captured sticky from the cycle after core_start; once all NUM_CORES flags are set, next state UNLOAD.
REQ-022 UNLOAD: read addresses 0..count-1, one per cycle; output_write_start=1 for consecutive cycles starting one cycle after UNLOAD entry.
REQ-023 output_write_done=1 only together with the final word; next cycle state=IDLE, output_write_start=0.
REQ-024 data_write_start/data_write_done are ignored outside IDLE/LOAD; core_done is ignored outside RUN.
REQ-025 load_ovf is cleared on the IDLE->LOAD transition.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, wr_ptr=0, count=0, done flags=0, load_ovf=0, and all outputs to 0 (mem_we, core_start, output_write_start, output_write_done, com_data_out, mem_addr, mem_wdata).
REQ-027 Reset mid-LOAD/RUN/UNLOAD SHALL abort with no further mem_we or output words; after release wait in IDLE.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: UNLOAD emits count+1 words; the extra last word is the modulo-2^DATA_W sum of all written load words, carrying output_write_done.
REQ-029 Macro undefined: no checksum logic; UNLOAD emits exactly count words.

Structure
REQ-030 Package mcp_loader_pkg SHALL hold the state encoding constants (IDLE/LOAD/RUN/UNLOAD) and the default parameter values.
REQ-031 Sub-module done_collector (NUM_CORES sticky flags, clear, all_done) SHALL implement REQ-020/021.

Verification
REQ-032 Load 5, 7, 9 (done with 9) -> mem writes addr 0..2; RUN; cores done -> outputs 5, 7, 9; done with 9.
REQ-033 Single word 42 with done in first LOAD cycle -> one output 42 carrying output_write_done.
REQ-034 ADDR_W=2, load 6 words -> 4 written, load_ovf=1, unload 4 words.
REQ-035 core_done bits rise at different cycles, core 0 held high before RUN -> UNLOAD only after all cores set after core_start.
REQ-036 rst pulsed during the 2nd UNLOAD word -> outputs 0 the same cycle, state=IDLE, no further words.
REQ-037 LOADER_CHECKSUM_EN, DATA_W=16, load 0xFFFF, 0x0002 -> outputs 0xFFFF, 0x0002, 0x0001 (done).

Source files
------------

// File: rtl/mem_stream_loader_pkg.sv
// Shared constants for the memory stream loader: FSM state encoding and
// default parameter values.
package mcp_loader_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_UNLOAD = 2'd3;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_NUM_CORES = 4;

endpackage

// File: rtl/mem_stream_loader_if.sv
// Host-side streaming bus of the memory stream loader: load words in,
// unload words out. The host drives through 'master', the loader uses 'slave'.
interface mem_stream_loader_if
    import mcp_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] com_data_in;
    logic              data_write_start;
    logic              data_write_done;
    logic [DATA_W-1:0] com_data_out;
    logic              output_write_start;
    logic              output_write_done;

    modport master (
        output com_data_in, data_write_start, data_write_done,
        input  com_data_out, output_write_start, output_write_done
    );

    modport slave (
        input  com_data_in, data_write_start, data_write_done,
        output com_data_out, output_write_start, output_write_done
    );
endinterface

// File: rtl/mem_stream_loader_done_collector.sv
// Per-core sticky completion flags. Flags clear on clear_i and accumulate
// core_done levels while capture_i is high; all_done_o when every core is set.
module done_collector #(
    parameter int NUM_CORES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 capture_i,
    input  logic [NUM_CORES-1:0] done_i,
    output logic                 all_done_o
);
    logic [NUM_CORES-1:0] flags_q, flags_d;

    // Next flag value: clear wins over capture, capture is a sticky OR.
    always_comb begin
        flags_d = flags_q;
        if (clear_i) begin
            flags_d = '0;
        end else if (capture_i) begin
            flags_d = flags_q | done_i;
        end
    end

    // Flag register, async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign all_done_o = &flags_q;
endmodule

// File: rtl/mem_stream_loader.sv
// Memory stream loader: loads host words into data memory, starts all cores,
// waits for every core to finish, then streams the memory back to the host.
// Optional macro LOADER_CHECKSUM_EN appends a modulo-2^DATA_W sum of the
// written load words as the final unload word.
module mem_stream_loader
    import mcp_loader_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_CORES = DEF_NUM_CORES
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_stream_loader_if.slave   host,
    output logic [1:0]           state,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic                 mem_we,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic [NUM_CORES-1:0] core_start,
    input  logic [NUM_CORES-1:0] core_done,
    output logic                 load_ovf
);
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]      state_q, state_d;
    logic [ADDR_W:0] count_q, count_d;      // words written; also the write pointer
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            ovf_q, ovf_d;
    logic            start_q, start_d;      // one-cycle core start pulse
    logic            out_vld_q, out_vld_d;
    logic            out_last_q, out_last_d;

    logic            full;
    logic [ADDR_W:0] n_out;
    logic            rd_issue;
    logic            rd_last;
    logic            all_done;

    assign full = count_q[ADDR_W];

`ifdef LOADER_CHECKSUM_EN
    assign n_out = count_q + ONE;
`else
    assign n_out = count_q;
`endif

    assign rd_issue = (state_q == ST_UNLOAD) && (rd_ptr_q < n_out);
    assign rd_last  = rd_issue && ((rd_ptr_q + ONE) == n_out);

    done_collector #(
        .NUM_CORES (NUM_CORES)
    ) u_done (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (start_q),
        .capture_i  ((state_q == ST_RUN) && !start_q),
        .done_i     (core_done),
        .all_done_o (all_done)
    );

    // FSM and pointer next-state logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        ovf_d      = ovf_q;
        start_d    = 1'b0;
        out_vld_d  = 1'b0;
        out_last_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (host.data_write_start) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
                if (host.data_write_done) begin
                    state_d = ST_RUN;
                    start_d = 1'b1;
                end
            end
            ST_RUN: begin
                // Flags may be stale from the previous run during the start cycle.
                if (all_done && !start_q) begin
                    state_d  = ST_UNLOAD;
                    rd_ptr_d = '0;
                end
            end
            ST_UNLOAD: begin
                if (rd_issue) begin
                    rd_ptr_d   = rd_ptr_q + ONE;
                    out_vld_d  = 1'b1;
                    out_last_d = rd_last;
                end
                if (out_last_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers, async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            start_q    <= 1'b0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            start_q    <= start_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
        end
    end

    // Memory address: write pointer in LOAD, read pointer for real words in UNLOAD.
    always_comb begin
        mem_addr = '0;
        if (state_q == ST_LOAD && !full) begin
            mem_addr = count_q[ADDR_W-1:0];
        end else if (state_q == ST_UNLOAD && rd_ptr_q < count_q) begin
            mem_addr = rd_ptr_q[ADDR_W-1:0];
        end
    end

    assign state      = state_q;
    assign mem_we     = (state_q == ST_LOAD) && !full;
    assign mem_wdata  = (state_q == ST_LOAD) ? host.com_data_in : '0;
    assign core_start = {NUM_CORES{start_q}};
    assign load_ovf   = ovf_q;

    assign host.output_write_start = out_vld_q;
    assign host.output_write_done  = out_last_q;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              sum_sel_q, sum_sel_d;

    // Checksum accumulates written words; the slot after the last address carries it.
    always_comb begin
        sum_d     = sum_q;
        sum_sel_d = rd_issue && (rd_ptr_q == count_q);
        if (state_q == ST_IDLE && host.data_write_start) begin
            sum_d = '0;
        end else if (mem_we) begin
            sum_d = sum_q + host.com_data_in;
        end
    end

    // Checksum registers, async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= '0;
            sum_sel_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            sum_sel_q <= sum_sel_d;
        end
    end

    assign host.com_data_out = !out_vld_q ? '0 : (sum_sel_q ? sum_q : mem_rdata);
`else
    assign host.com_data_out = out_vld_q ? mem_rdata : '0;
`endif
endmodule

// File: tb/tb_mem_stream_loader.sv
// Directed bench for mem_stream_loader with a memory model and scoreboard
// queues for expected memory writes and expected unload words.
module tb_mem_stream_loader;
    import mcp_loader_pkg::*;

    localparam int DW = 16;
    localparam int AW = 2;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stream_loader_if #(.DATA_W(DW)) host ();

    logic [1:0]    state;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_we;
    logic [NC-1:0] core_start;
    logic [NC-1:0] core_done;
    logic          load_ovf;

    mem_stream_loader #(.DATA_W(DW), .ADDR_W(AW), .NUM_CORES(NC)) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (host),
        .state      (state),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .core_start (core_start),
        .core_done  (core_done),
        .load_ovf   (load_ovf)
    );

    // Data memory: synchronous write, read data one cycle after address.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_wr[$];
    logic [DW-1:0] exp_out[$];
    logic [DW-1:0] sum_m;
    int            n_wr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: compare memory writes and unload words against the scoreboard.
    wr_t           mon_w;
    logic [DW-1:0] mon_d;
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", mem_we, 0);
            end else begin
                mon_w = exp_wr.pop_front();
                check("wr_addr", mem_addr, mon_w.addr);
                check("wr_data", mem_wdata, mon_w.data);
            end
        end
        if (!rst && host.output_write_start) begin
            if (exp_out.size() == 0) begin
                check("unexpected_out", host.output_write_start, 0);
            end else begin
                mon_d = exp_out.pop_front();
                check("out_data", host.com_data_out, mon_d);
                check("out_done", host.output_write_done, exp_out.size() == 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_load();
        host.data_write_start = 1'b1;
        step();
        host.data_write_start = 1'b0;
        sum_m = '0;
        n_wr  = 0;
    endtask

    task automatic load_word(input logic [DW-1:0] w, input logic last);
        wr_t e;
        host.com_data_in     = w;
        host.data_write_done = last;
        if (n_wr < (1 << AW)) begin
            e.addr = AW'(n_wr);
            e.data = w;
            exp_wr.push_back(e);
            exp_out.push_back(w);
            sum_m = sum_m + w;
            n_wr++;
        end
`ifdef LOADER_CHECKSUM_EN
        if (last) exp_out.push_back(sum_m);
`endif
        step();
        host.data_write_done = 1'b0;
    endtask

    task automatic check_run_entry(input string tag);
        check({tag, "_run"}, state, ST_RUN);
        check({tag, "_core_start"}, core_start, {NC{1'b1}});
    endtask

    task automatic wait_unload(input string tag);
        int k;
        k = 0;
        while (state !== ST_UNLOAD && k < 50) begin
            step();
            k++;
        end
        check({tag, "_enter_unload"}, state, ST_UNLOAD);
        check({tag, "_ows_at_entry"}, host.output_write_start, 0);
        k = 0;
        while (state !== ST_IDLE && k < 50) begin
            step();
            k++;
        end
        check({tag, "_back_idle"}, state, ST_IDLE);
        check({tag, "_words_left"}, exp_out.size(), 0);
        check({tag, "_ows_idle"}, host.output_write_start, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst                   = 1'b1;
        host.com_data_in      = '0;
        host.data_write_start = 1'b0;
        host.data_write_done  = 1'b0;
        core_done             = '0;
        #12;
        check("rst_state", state, ST_IDLE);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_core_start", core_start, 0);
        check("rst_ows", host.output_write_start, 0);
        check("rst_owd", host.output_write_done, 0);
        check("rst_dout", host.com_data_out, 0);
        check("rst_ovf", load_ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("idle_hold", state, ST_IDLE);

        // Basic three-word load / run / unload.
        begin_load();
        check("t1_load", state, ST_LOAD);
        load_word(16'd5, 1'b0);
        load_word(16'd7, 1'b0);
        load_word(16'd9, 1'b1);
        check_run_entry("t1");
        core_done = '1;
        step();
        check("t1_start_pulse_len", core_start, 0);
        wait_unload("t1");
        core_done = '0;

        // Overflow: six words into a four-word memory.
        begin_load();
        for (int i = 0; i < 6; i++) load_word(DW'(16'h100 + i), i == 5);
        check("ovf_set", load_ovf, 1);
        check_run_entry("ovf");
        core_done = '1;
        wait_unload("ovf");
        core_done = '0;
        check("ovf_sticky", load_ovf, 1);

        // Single word with done in the first LOAD cycle.
        begin_load();
        check("ovf_cleared", load_ovf, 0);
        load_word(16'd42, 1'b1);
        check_run_entry("single");
        core_done = '1;
        wait_unload("single");
        core_done = '0;

        // Staggered core completion, core 0 already high before RUN.
        begin_load();
        core_done = 4'b0001;
        load_word(16'd11, 1'b0);
        load_word(16'd22, 1'b1);
        check_run_entry("stagger");
        host.data_write_start = 1'b1;
        step();
        core_done = 4'b0011;
        step();
        step();
        core_done = 4'b0111;
        repeat (4) step();
        check("stagger_partial_hold", state, ST_RUN);
        host.data_write_start = 1'b0;
        core_done = 4'b1111;
        wait_unload("stagger");
        core_done = '0;

        // Reset during the second unload word.
        begin_load();
        load_word(16'd1, 1'b0);
        load_word(16'd2, 1'b0);
        load_word(16'd3, 1'b1);
        core_done = '1;
        k = 0;
        while (host.output_write_start !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        check("rst_mid_first_word", host.output_write_start, 1);
        step();
        check("rst_mid_second_word", host.com_data_out, 2);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_state", state, ST_IDLE);
        check("rst_mid_ows", host.output_write_start, 0);
        check("rst_mid_owd", host.output_write_done, 0);
        check("rst_mid_dout", host.com_data_out, 0);
        check("rst_mid_core_start", core_start, 0);
        exp_out.delete();
        core_done = '0;
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (5) step();
        check("rst_after_state", state, ST_IDLE);
        check("rst_after_ows", host.output_write_start, 0);

        // Wrap-around words (checksum 0x0001 when the checksum build is used).
        begin_load();
        load_word(16'hFFFF, 1'b0);
        load_word(16'h0002, 1'b1);
        check_run_entry("cksum");
        core_done = '1;
        wait_unload("cksum");
        core_done = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
